// File: rtl/bus_demux_1to2.sv
// Routes one CPU bus transaction to target A (RAM) or B (MMIO) by one address bit and returns its response.
// Optional abort timer enabled by defining BUS_DEMUX_TIMEOUT_EN.
module bus_demux_1to2 #(
    parameter int unsigned SEL_BIT = 28,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic [31:0] Req_Addr,
    input  logic [31:0] Req_WData,
    input  logic        Req_We,
    output logic        Rsp_Valid,
    output logic [31:0] Rsp_RData,
    output logic        Rsp_Err,
    output logic        A_Valid,
    input  logic        A_Ready,
    output logic [31:0] A_Addr,
    output logic [31:0] A_WData,
    output logic        A_We,
    input  logic        A_RspValid,
    input  logic [31:0] A_RData,
    output logic        B_Valid,
    input  logic        B_Ready,
    output logic [31:0] B_Addr,
    output logic [31:0] B_WData,
    output logic        B_We,
    input  logic        B_RspValid,
    input  logic [31:0] B_RData
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        we_q, dest_q, ready_q, err_q;
    logic        accept, sel_ready, sel_rsp, timeout;
    logic [31:0] sel_rdata;

    assign accept    = Req_Valid & ready_q;
    assign sel_ready = dest_q ? B_Ready    : A_Ready;
    assign sel_rsp   = dest_q ? B_RspValid : A_RspValid;
    assign sel_rdata = dest_q ? B_RData    : A_RData;

`ifdef BUS_DEMUX_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                                      cnt_q <= '0;
        else if (accept)                                 cnt_q <= '0;
        else if (state_q == S_ISSUE || state_q == S_WAIT) cnt_q <= cnt_q + 1'b1;
    end

    // Fires in the cycle the count would reach TIMEOUT, so RESP lands TIMEOUT cycles after ISSUE entry.
    assign timeout = (state_q == S_ISSUE || state_q == S_WAIT) &&
                     (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_ISSUE;
            S_ISSUE: if (timeout) state_d = S_RESP;
                     else if (sel_ready) state_d = S_WAIT;
            S_WAIT:  if (sel_rsp || timeout) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            dest_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state_d == S_IDLE);
            if (accept) begin
                addr_q  <= Req_Addr;
                wdata_q <= Req_WData;
                we_q    <= Req_We;
                dest_q  <= Req_Addr[SEL_BIT];
                err_q   <= 1'b0;
            end
            // A response in the timeout cycle takes priority over the abort.
            if (state_q == S_WAIT && sel_rsp) begin
                rdata_q <= sel_rdata;
                err_q   <= 1'b0;
            end else if (timeout) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    always_comb begin
        A_Valid   = 1'b0;
        A_Addr    = '0;
        A_WData   = '0;
        A_We      = 1'b0;
        B_Valid   = 1'b0;
        B_Addr    = '0;
        B_WData   = '0;
        B_We      = 1'b0;
        if (state_q == S_ISSUE) begin
            if (dest_q) begin
                B_Valid = 1'b1;
                B_Addr  = addr_q;
                B_WData = wdata_q;
                B_We    = we_q;
            end else begin
                A_Valid = 1'b1;
                A_Addr  = addr_q;
                A_WData = wdata_q;
                A_We    = we_q;
            end
        end
        Req_Ready = ready_q;
        Rsp_Valid = (state_q == S_RESP);
        Rsp_RData = Rsp_Valid ? rdata_q : '0;
`ifdef BUS_DEMUX_TIMEOUT_EN
        Rsp_Err   = Rsp_Valid & err_q;
`else
        // No abort path in this build: error flag is constant zero (TIMEOUT is referenced only to stay live).
        Rsp_Err   = 1'b0 & (TIMEOUT < 2) & err_q;
`endif
    end

endmodule

// File: doc/bus_demux_1to2.md
# bus_demux_1to2

Routes a single CPU data-bus transaction to one of two targets: target A (data RAM) or target B (memory-mapped I/O). One address bit selects the target. The block returns that target's response upstream, so it is the inverse of the 2:1 result mux on the datapath side. It sits between the core's load/store unit and the memory/peripheral subsystems and allows one outstanding transaction at a time.

## Interface
- Parameters:
  - `SEL_BIT`, 28: address bit that picks the target. 0 selects A, 1 selects B.
  - `TIMEOUT`, 16: cycles allowed in ISSUE+WAIT before abort. Must be ≥2. Used only when `BUS_DEMUX_TIMEOUT_EN` is defined.
- Ports: one clock; reset is asynchronous and active-low.
  - `Clk` in 1: clock, rising edge.
  - `Rst_n` in 1: asynchronous active-low reset.
  - `Req_Valid` in 1, `Req_Ready` out 1: upstream request handshake.
  - `Req_Addr` in 32, `Req_WData` in 32, `Req_We` in 1: request address, write data, write enable.
  - `Rsp_Valid` out 1, `Rsp_RData` out 32, `Rsp_Err` out 1: upstream response, no backpressure.
  - `A_Valid` out 1, `A_Ready` in 1, `A_Addr` out 32, `A_WData` out 32, `A_We` out 1: target A request.
  - `A_RspValid` in 1, `A_RData` in 32: target A response.
  - `B_*`: same seven ports as A, for target B.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered or decoded from state registers; there are no combinational input-to-output paths.
- IDLE:
  - `Req_Ready`=1.
  - On `Req_Valid`&`Req_Ready`, capture Addr, WData and We, latch `Dest`=`Req_Addr[SEL_BIT]`, go to ISSUE.
- ISSUE:
  - Selected target gets `X_Valid`=1 with the captured Addr, WData and We.
  - All outputs of the unselected target are 0.
  - On `X_Ready`=1, go to WAIT. `X_Valid` is held until that handshake.
- WAIT:
  - `X_Valid`=0.
  - On the selected target's `X_RspValid`, capture `X_RData`, go to RESP.
  - For writes the target returns RData=0.
- RESP:
  - `Rsp_Valid`=1 for exactly one cycle with the captured data, then go to IDLE.
  - Upstream must accept the response in that cycle.
- Full address and data pass through unmodified. `SEL_BIT` is not stripped.
- The unselected target's `X_RspValid` is ignored in every state.
- `X_RspValid` is ignored outside WAIT. A target must not respond in the same cycle as its Ready handshake.
- `Req_Valid` while busy is not accepted. Upstream holds its request.
- Reset values:
  - `Req_Ready`=0. It rises one cycle after `Rst_n` deasserts, then equals (state==IDLE).
  - `Rsp_Valid`=0, `Rsp_RData`=0, `Rsp_Err`=0.
  - All A_* and B_* outputs = 0.
  - State = IDLE.
- Reset mid-operation:
  - The transaction is abandoned and target Valids drop asynchronously.
  - Late target responses arrive in IDLE and are ignored.
  - No upstream response is produced.

## Timing
- Accept at cycle 0 → `X_Valid` in cycle 1. With `X_Ready`=1 in cycle 1 and `X_RspValid` in cycle 2 → `Rsp_Valid` in cycle 3.
- Minimum latency is 3 cycles from acceptance to response.
- `Req_Ready` returns in cycle 4, so peak throughput is one transaction per 4 cycles.
- Each target stall cycle (Ready low, or no response yet) adds exactly one cycle.

## Configuration
- `BUS_DEMUX_TIMEOUT_EN` defined:
  - A counter of width $clog2(TIMEOUT+1) clears on acceptance and increments each cycle in ISSUE or WAIT.
  - When it reaches `TIMEOUT`, the FSM goes to RESP with `Rsp_Err`=1 and `Rsp_RData`=0, and drops `X_Valid`.
  - A response in the same cycle as the timeout wins: normal data, `Rsp_Err`=0.
- Not defined: no counter, the FSM waits indefinitely, and `Rsp_Err` is tied to 0.

## Test plan
- Read to A: Addr=0x0000_0010, A_Ready=1, A_RspValid the next cycle with 0x1234_5678 → A_Valid in cycle 1, B_* all 0, Rsp_Valid in cycle 3 with RData=0x1234_5678, Err=0.
- Write to B: Addr=0x1000_0004, WData=0xCAFE_F00D, We=1, B_Ready low for 2 cycles → B_Valid held 3 cycles with stable fields, Rsp_Valid in cycle 5, A_* all 0.
- Cross-talk: during a B read, pulse A_RspValid with 0xFFFF_FFFF, then B responds 0x0000_00AA → Rsp_RData=0x0000_00AA.
- Back-to-back: Req_Valid held high across two requests (A, then B) → second accepted only in cycle 4, responses in order, Req_Ready never high while busy.
- Reset in WAIT: Rst_n low for 1 cycle, then target responds → all outputs 0 during reset, no Rsp_Valid afterwards, Req_Ready=1 one cycle after release.
- With BUS_DEMUX_TIMEOUT_EN and TIMEOUT=16, target never responds → Rsp_Valid exactly 16 cycles after ISSUE entry, Err=1, RData=0; without the macro, no response after 100 cycles.
